tile_table: RTL and testbench



---
 rtl/tile_table.sv | 190 +++++++++++++++++++
 tb/tb_tile_table.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_table.sv
// tile_table: game-board tile memory, COLS x ROWS cells of 8-bit sprite codes.
//
// Game side (update/get, level inputs, one op per rising edge) has one RAM access per
// cycle through a small FSM; the video scanout has its own registered read port.
//
// Optional feature macro: TILE_TABLE_INIT_EN
//   defined   - reset sweeps CLEAR_CODE into every cell (busy high meanwhile)
//   undefined - reset goes straight to idle, busy is tied low, RAM keeps its contents
//
// Ports:
//   px_clk, rst              pixel clock, synchronous active-high reset
//   update, posx, posy,      write request (rising edge), cell coords, sprite code
//   sprite
//   get                      read request (rising edge) at posx/posy
//   read_sprite, read_valid  read data and its one-cycle valid pulse
//   busy                     clear sweep in progress, requests dropped
//   vid_x, vid_y, vid_tile   scanout lookup, one cycle registered latency
module tile_table #(
  parameter int unsigned COLS       = 40,
  parameter int unsigned ROWS       = 30,
  parameter logic [7:0]  CLEAR_CODE = 8'd0
) (
  input  logic       px_clk,
  input  logic       rst,
  input  logic       update,
  input  logic [5:0] posx,
  input  logic [5:0] posy,
  input  logic [7:0] sprite,
  input  logic       get,
  output logic [7:0] read_sprite,
  output logic       read_valid,
  output logic       busy,
  input  logic [5:0] vid_x,
  input  logic [5:0] vid_y,
  output logic [7:0] vid_tile
);

  localparam int unsigned Depth = COLS * ROWS;
  localparam int unsigned AddrW = $clog2(Depth);

  typedef enum logic [1:0] {StClear, StIdle, StWrite, StRead} state_e;

`ifdef TILE_TABLE_INIT_EN
  localparam state_e ResetState = StClear;
`else
  localparam state_e ResetState = StIdle;
`endif

  function automatic logic in_range(input logic [5:0] x, input logic [5:0] y);
    return (32'(x) < COLS) && (32'(y) < ROWS);
  endfunction

  // Out-of-range cells map to address 0 so the RAM is never indexed past its end;
  // every user masks the data with in_range().
  function automatic logic [AddrW-1:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
    if (!in_range(x, y)) return '0;
    return AddrW'(y) * AddrW'(COLS) + AddrW'(x);
  endfunction

  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_addr_q, clr_addr_d;
  logic             update_q, get_q;
  logic [5:0]       cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic [7:0]       cap_data_q, cap_data_d;
  logic             pending_get_q, pending_get_d;
  logic [7:0]       read_sprite_q, read_sprite_d;
  logic             read_valid_q, read_valid_d;
  logic [7:0]       vid_tile_q, vid_tile_d;

  logic             upd_edge, get_edge;
  logic             cap_in;
  logic [AddrW-1:0] cap_addr;
  logic             mem_we;
  logic [AddrW-1:0] mem_waddr;
  logic [7:0]       mem_wdata;
  logic             rd_fire;

  logic [7:0] mem [Depth];

  assign upd_edge = update & ~update_q;
  assign get_edge = get & ~get_q;
  assign cap_in   = in_range(cap_x_q, cap_y_q);
  assign cap_addr = cell_addr(cap_x_q, cap_y_q);

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    cap_x_d       = cap_x_q;
    cap_y_d       = cap_y_q;
    cap_data_d    = cap_data_q;
    pending_get_d = pending_get_q;
    mem_we        = 1'b0;
    mem_waddr     = '0;
    mem_wdata     = CLEAR_CODE;
    rd_fire       = 1'b0;

    unique case (state_q)
`ifdef TILE_TABLE_INIT_EN
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        if (clr_addr_q == AddrW'(Depth - 1)) begin
          clr_addr_d = '0;
          state_d    = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
`endif
      StIdle: begin
        if (upd_edge) begin
          cap_x_d       = posx;
          cap_y_d       = posy;
          cap_data_d    = sprite;
          // A simultaneous get is served after the write, so it sees the new value.
          pending_get_d = get_edge;
          state_d       = StWrite;
        end else if (get_edge) begin
          cap_x_d = posx;
          cap_y_d = posy;
          state_d = StRead;
        end
      end
      StWrite: begin
        mem_we        = cap_in;
        mem_waddr     = cap_addr;
        mem_wdata     = cap_data_q;
        pending_get_d = 1'b0;
        state_d       = pending_get_q ? StRead : StIdle;
      end
      StRead: begin
        rd_fire = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    read_sprite_d = read_sprite_q;
    read_valid_d  = rd_fire;
    if (rd_fire) read_sprite_d = cap_in ? mem[cap_addr] : CLEAR_CODE;
    vid_tile_d = in_range(vid_x, vid_y) ? mem[cell_addr(vid_x, vid_y)] : CLEAR_CODE;
  end

  // RAM has no reset; rst only blocks a write that would land in the reset cycle.
  always_ff @(posedge px_clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      state_q       <= ResetState;
      clr_addr_q    <= '0;
      // Start high so a level already asserted during reset is not seen as an edge.
      update_q      <= 1'b1;
      get_q         <= 1'b1;
      cap_x_q       <= '0;
      cap_y_q       <= '0;
      cap_data_q    <= '0;
      pending_get_q <= 1'b0;
      read_sprite_q <= '0;
      read_valid_q  <= 1'b0;
      vid_tile_q    <= '0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      update_q      <= update;
      get_q         <= get;
      cap_x_q       <= cap_x_d;
      cap_y_q       <= cap_y_d;
      cap_data_q    <= cap_data_d;
      pending_get_q <= pending_get_d;
      read_sprite_q <= read_sprite_d;
      read_valid_q  <= read_valid_d;
      vid_tile_q    <= vid_tile_d;
    end
  end

`ifdef TILE_TABLE_INIT_EN
  assign busy = (state_q == StClear);
`else
  assign busy = 1'b0;
`endif

  assign read_sprite = read_sprite_q;
  assign read_valid  = read_valid_q;
  assign vid_tile    = vid_tile_q;

endmodule

// File: tb/tb_tile_table.sv
// Bench for tile_table: transaction-level model of the board (logical view for game
// reads, delayed view for the scanout port), checked every cycle, plus directed
// literal checks of the main scenarios.
module tb_tile_table;

  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int NCELL = COLS * ROWS;
  localparam logic [7:0] CLR = 8'h00;

  logic       px_clk = 1'b0;
  logic       rst = 1'b1;
  logic       update = 1'b0;
  logic [5:0] posx = '0;
  logic [5:0] posy = '0;
  logic [7:0] sprite = '0;
  logic       get = 1'b0;
  logic [7:0] read_sprite;
  logic       read_valid;
  logic       busy;
  logic [5:0] vid_x = '0;
  logic [5:0] vid_y = '0;
  logic [7:0] vid_tile;

  tile_table dut (
    .px_clk     (px_clk),
    .rst        (rst),
    .update     (update),
    .posx       (posx),
    .posy       (posy),
    .sprite     (sprite),
    .get        (get),
    .read_sprite(read_sprite),
    .read_valid (read_valid),
    .busy       (busy),
    .vid_x      (vid_x),
    .vid_y      (vid_y),
    .vid_tile   (vid_tile)
  );

  always #5 px_clk = ~px_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int at; int a; byte unsigned v;} vwr_t;

  byte unsigned lmem [NCELL];
  bit           lknown [NCELL];
  byte unsigned vmem [NCELL];
  bit           vknown [NCELL];
  vwr_t         vq [$];

  int           c = 0;
  bit           started = 0;
  int           free_at = 1 << 30;
  int           busy_until = 0;
  int           vid_skip = 0;
  int           rv_due = -1;
  byte unsigned rv_val;
  bit           rv_known;
  byte unsigned exp_rs;
  bit           exp_rs_known = 0;
  byte unsigned exp_vid;
  bit           exp_vid_known = 0;
  bit           prev_upd = 1, prev_get = 1;

  initial begin
    for (int i = 0; i < NCELL; i++) begin
      lknown[i] = 0;
      vknown[i] = 0;
    end
  end

  always @(negedge px_clk) begin : model
    bit upd_e, get_e, inr, vinr;
    int a, va;
    c++;
    if (started) begin
      if (c == rv_due) begin
        exp_rs       = rv_val;
        exp_rs_known = rv_known;
      end
      check("read_valid", int'(read_valid), int'(c == rv_due));
      if (exp_rs_known) check("read_sprite", int'(read_sprite), int'(exp_rs));
      if (exp_vid_known) check("vid_tile", int'(vid_tile), int'(exp_vid));
      check("busy", int'(busy), int'(c < busy_until));
    end
    // writes become visible to the scanout two cycles after their request edge
    while (vq.size() > 0 && vq[0].at <= c) begin
      vmem[vq[0].a]   = vq[0].v;
      vknown[vq[0].a] = 1;
      void'(vq.pop_front());
    end
    if (rst) begin
      started       = 1;
      rv_due        = -1;
      exp_rs        = 0;
      exp_rs_known  = 1;
      exp_vid       = 0;
      exp_vid_known = 1;
      prev_upd      = 1;
      prev_get      = 1;
`ifdef TILE_TABLE_INIT_EN
      busy_until = c + 1201;
      free_at    = c + 1201;
      vid_skip   = c + 1201;
      vq.delete();
      for (int i = 0; i < NCELL; i++) begin
        lmem[i] = CLR; lknown[i] = 1; vmem[i] = CLR; vknown[i] = 1;
      end
`else
      busy_until = 0;
      free_at    = c + 1;
`endif
    end else begin
      upd_e = update && !prev_upd;
      get_e = get && !prev_get;
      if (c >= free_at && (upd_e || get_e)) begin
        inr = (int'(posx) < COLS) && (int'(posy) < ROWS);
        a   = inr ? int'(posy) * COLS + int'(posx) : 0;
        if (upd_e) begin
          if (inr) begin
            lmem[a]   = sprite;
            lknown[a] = 1;
            vq.push_back('{c + 2, a, sprite});
          end
          free_at = get_e ? c + 3 : c + 2;
          if (get_e) rv_due = c + 3;
        end else begin
          free_at = c + 2;
          rv_due  = c + 2;
        end
        if (get_e) begin
          rv_val   = inr ? lmem[a] : CLR;
          rv_known = !inr || lknown[a];
        end
      end
      vinr          = (int'(vid_x) < COLS) && (int'(vid_y) < ROWS);
      va            = vinr ? int'(vid_y) * COLS + int'(vid_x) : 0;
      exp_vid       = vinr ? vmem[va] : CLR;
      exp_vid_known = (c >= vid_skip) && (!vinr || vknown[va]);
      prev_upd      = update;
      prev_get      = get;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic do_write(input int x, input int y, input logic [7:0] d);
    posx = 6'(x); posy = 6'(y); sprite = d; update = 1'b1;
    tick();
    update = 1'b0;
    tick();
  endtask

  // Issues a get (optionally with a simultaneous update) and measures latency to read_valid.
  task automatic do_get(input int x, input int y, input bit with_upd, input logic [7:0] d,
                        output int lat, output logic [7:0] val);
    posx = 6'(x); posy = 6'(y); sprite = d; get = 1'b1; update = with_upd;
    lat = 0; val = 8'hxx;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin get = 1'b0; update = 1'b0; end
      if (read_valid) begin lat = k; val = read_sprite; break; end
    end
    tick();
  endtask

  task automatic busy_len(output int cnt);
    cnt = 0;
    while (busy && cnt < 1300) begin cnt++; tick(); end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat, cnt;
    logic [7:0] val;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
`ifdef TILE_TABLE_INIT_EN
    busy_len(cnt);
    check("clear_busy_len", cnt, 1200);
    do_get(0, 0, 0, 8'h00, lat, val);
    check("clear_get_0_0", int'(val), 0);
    do_get(39, 29, 0, 8'h00, lat, val);
    check("clear_get_39_29", int'(val), 0);
`else
    tick();
`endif
    // fill every cell with known random data
    for (int i = 0; i < NCELL; i++) do_write(i % COLS, i / COLS, 8'($urandom));

    // write then read
    do_write(5, 7, 8'h47);
    do_get(5, 7, 0, 8'h00, lat, val);
    check("get_latency", lat, 2);
    check("get_5_7", int'(val), 8'h47);
    vid_x = 6'd5; vid_y = 6'd7;
    tick();
    check("vid_5_7", int'(vid_tile), 8'h47);

    // held update level: only the first edge writes
    posx = 6'd2; posy = 6'd2; sprite = 8'h01; update = 1'b1;
    tick();
    sprite = 8'h02;
    repeat (39) tick();
    update = 1'b0;
    tick();
    do_get(2, 2, 0, 8'h00, lat, val);
    check("held_level", int'(val), 8'h01);

    // simultaneous update + get
    do_get(10, 3, 1, 8'hA5, lat, val);
    check("simul_latency", lat, 3);
    check("simul_value", int'(val), 8'hA5);

    // out of range
    do_write(40, 3, 8'hFF);
    do_write(3, 30, 8'hFF);
    for (int i = 0; i < NCELL; i++) begin
      vid_x = 6'(i % COLS); vid_y = 6'(i / COLS);
      tick();
    end
    do_get(63, 63, 0, 8'h00, lat, val);
    check("oor_latency", lat, 2);
    check("oor_get", int'(val), int'(CLR));
    vid_x = 6'd50; vid_y = 6'd1;
    tick();
    tick();
    check("oor_vid", int'(vid_tile), int'(CLR));

    // random traffic, including edges that land mid-op and get dropped
    for (int i = 0; i < 3000; i++) begin
      update = ($urandom_range(0, 2) == 0);
      get    = ($urandom_range(0, 2) == 0);
      posx   = 6'($urandom_range(0, 44));
      posy   = 6'($urandom_range(0, 33));
      sprite = 8'($urandom);
      vid_x  = 6'($urandom_range(0, 44));
      vid_y  = 6'($urandom_range(0, 33));
      tick();
    end
    update = 1'b0;
    get = 1'b0;
    repeat (5) tick();

    // reset while idle, then confirm the table still works
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef TILE_TABLE_INIT_EN
    busy_len(cnt);
    check("reset_busy_len", cnt, 1200);
    // reset mid-clear restarts the sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (601) tick();
    check("midclear_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_len(cnt);
    check("midclear_busy_len", cnt, 1200);
`else
    tick();
`endif
    do_write(1, 1, 8'h3C);
    do_get(1, 1, 0, 8'h00, lat, val);
    check("post_reset_write", int'(val), 8'h3C);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
